// File: rtl/sram_req_seq.sv
// Slot sequencer and two-client (video read / CPU read-write) requester for the external SRAM.
// Optional round-robin arbitration when SRAM_REQ_FAIR_EN is defined; fixed priority (port 0 first) otherwise.
module sram_req_seq #(
    parameter int SLOT_LEN = 8,
    parameter int RD_LAT   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [20:0] p0_addr,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    output logic        p0_rvalid,
    input  logic        p1_req,
    input  logic        p1_rnw,
    input  logic [20:0] p1_addr,
    input  logic [15:0] p1_wrdata,
    input  logic [1:0]  p1_bsel,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic        p1_rvalid,
    output logic        cyc,
    output logic        c0,
    output logic        c1,
    output logic        c2,
    output logic        c3,
    output logic        req,
    output logic        rnw,
    output logic [20:0] addr,
    output logic [15:0] wrdata,
    output logic [1:0]  bsel,
    input  logic [15:0] sram_do
);

    localparam int CW = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] CNT_RD   = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_PH1  = CW'(SLOT_LEN / 4);
    localparam logic [CW-1:0] CNT_PH2  = CW'(SLOT_LEN / 2);
    localparam logic [CW-1:0] CNT_PH3  = CW'(3 * SLOT_LEN / 4);

    logic [CW-1:0] cnt;
    logic          owner;      // port that owns the current slot: 0 = video, 1 = CPU
    logic          grant0;
    logic          grant1;
    logic          arb_point;
    logic          capture;

`ifdef SRAM_REQ_FAIR_EN
    logic          last_owner; // port granted most recently; resets to CPU so video wins first contention
`endif

    assign arb_point = (cnt == CNT_LAST);
    assign capture   = (cnt == CNT_RD) && req && rnw;

    // Phase strobes decode the counter directly; held low during reset.
    assign cyc = rst_n && (cnt == '0);
    assign c0  = cyc;
    assign c1  = rst_n && (cnt == CNT_PH1);
    assign c2  = rst_n && (cnt == CNT_PH2);
    assign c3  = rst_n && (cnt == CNT_PH3);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef SRAM_REQ_FAIR_EN
        if (p0_req && p1_req) begin
            grant0 = last_owner;
            grant1 = ~last_owner;
        end else begin
            grant0 = p0_req;
            grant1 = p1_req;
        end
`else
        grant0 = p0_req;
        grant1 = p1_req && !p0_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (arb_point) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Command registers load only at the slot boundary, so they are stable for the whole slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req    <= 1'b0;
            rnw    <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
            bsel   <= '0;
            owner  <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (arb_point) begin
                req <= grant0 || grant1;
                if (grant0) begin
                    rnw    <= 1'b1;
                    addr   <= p0_addr;
                    bsel   <= 2'b11;
                    owner  <= 1'b0;
                    p0_ack <= 1'b1;
                end else if (grant1) begin
                    rnw    <= p1_rnw;
                    addr   <= p1_addr;
                    wrdata <= p1_wrdata;
                    bsel   <= p1_bsel;
                    owner  <= 1'b1;
                    p1_ack <= 1'b1;
                end
            end
        end
    end

`ifdef SRAM_REQ_FAIR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
        end else if (arb_point && (grant0 || grant1)) begin
            last_owner <= grant1;
        end
    end
`endif

    // Read return: capture uses the current slot's command before any reload at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            if (capture) begin
                if (owner) begin
                    p1_rdata  <= sram_do;
                    p1_rvalid <= 1'b1;
                end else begin
                    p0_rdata  <= sram_do;
                    p0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_req_seq.sv
// Self-checking bench for sram_req_seq: slot-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_req_seq;

    localparam int SL = 8;
    localparam int RL = 7;

    logic        clk;
    logic        rst_n;
    logic        p0_req;
    logic [20:0] p0_addr;
    logic        p0_ack;
    logic [15:0] p0_rdata;
    logic        p0_rvalid;
    logic        p1_req;
    logic        p1_rnw;
    logic [20:0] p1_addr;
    logic [15:0] p1_wrdata;
    logic [1:0]  p1_bsel;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic        p1_rvalid;
    logic        cyc, c0, c1, c2, c3;
    logic        req, rnw;
    logic [20:0] addr;
    logic [15:0] wrdata;
    logic [1:0]  bsel;
    logic [15:0] sram_do;

    int checks = 0;
    int errors = 0;

    sram_req_seq #(.SLOT_LEN(SL), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
        .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr),
        .p1_wrdata(p1_wrdata), .p1_bsel(p1_bsel), .p1_ack(p1_ack),
        .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .cyc(cyc), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .req(req), .rnw(rnw), .addr(addr), .wrdata(wrdata), .bsel(bsel),
        .sram_do(sram_do)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Reference model: slot position is time since reset release modulo SL; one command per slot.
    int          m_cnt;
    int          m_own;
    int          m_last;
    logic        e_req, e_rnw, e_ack0, e_ack1, e_rv0, e_rv1;
    logic [20:0] e_addr;
    logic [15:0] e_wrdata, e_rd0, e_rd1;
    logic [1:0]  e_bsel;
    logic        m_in_rst;

    always @(posedge clk) begin
        int win;
        if (!rst_n) begin
            m_cnt = 0; m_own = 0; m_last = 1; m_in_rst = 1'b1;
            e_req = 0; e_rnw = 0; e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0;
            e_addr = 0; e_wrdata = 0; e_bsel = 0; e_rd0 = 0; e_rd1 = 0;
        end else begin
            m_in_rst = 1'b0;
            e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0;
            if (m_cnt == RL && e_req && e_rnw) begin
                if (m_own == 0) begin e_rd0 = sram_do; e_rv0 = 1; end
                else            begin e_rd1 = sram_do; e_rv1 = 1; end
            end
            if (m_cnt == SL - 1) begin
                win = -1;
                if (p0_req && p1_req) begin
`ifdef SRAM_REQ_FAIR_EN
                    win = (m_last == 1) ? 0 : 1;
`else
                    win = 0;
`endif
                end else if (p0_req) win = 0;
                else if (p1_req) win = 1;
                e_req = (win >= 0);
                if (win == 0) begin
                    e_rnw = 1; e_addr = p0_addr; e_bsel = 2'b11; e_ack0 = 1;
                end else if (win == 1) begin
                    e_rnw = p1_rnw; e_addr = p1_addr; e_wrdata = p1_wrdata;
                    e_bsel = p1_bsel; e_ack1 = 1;
                end
                if (win >= 0) begin m_own = win; m_last = win; end
            end
            m_cnt = (m_cnt + 1) % SL;
        end
    end

    // compare process
    always @(negedge clk) begin
        chk("cyc", 32'(cyc), 32'(rst_n && m_cnt == 0));
        chk("c0",  32'(c0),  32'(rst_n && m_cnt == 0));
        chk("c1",  32'(c1),  32'(rst_n && m_cnt == SL / 4));
        chk("c2",  32'(c2),  32'(rst_n && m_cnt == SL / 2));
        chk("c3",  32'(c3),  32'(rst_n && m_cnt == 3 * SL / 4));
        chk("req", 32'(req), 32'(e_req));
        chk("p0_ack", 32'(p0_ack), 32'(e_ack0));
        chk("p1_ack", 32'(p1_ack), 32'(e_ack1));
        chk("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
        chk("p0_rdata", 32'(p0_rdata), 32'(e_rd0));
        chk("p1_rdata", 32'(p1_rdata), 32'(e_rd1));
        if (e_req || m_in_rst) begin
            chk("rnw",    32'(rnw),    32'(e_rnw));
            chk("addr",   32'(addr),   32'(e_addr));
            chk("bsel",   32'(bsel),   32'(e_bsel));
            if (!e_rnw) chk("wrdata", 32'(wrdata), 32'(e_wrdata));
        end
    end

    // read-data source: random unless a directed test pins it
    logic hold_do = 1'b0;
    always @(posedge clk) begin
        #3;
        if (!hold_do) sram_do = 16'($urandom);
    end

    // ack-order scoreboard for the contention scenario
    logic       log_acks = 1'b0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    always @(negedge clk) begin
        if (log_acks) begin
            if (p0_ack) got_q.push_back(1'b0);
            if (p1_ack) got_q.push_back(1'b1);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int k);
        for (int i = 0; i < 4 * SL; i++) begin
            step();
            if (m_cnt == k) return;
        end
        timeout_fail("wait_cnt");
    endtask

    task automatic wait_ack(input int port, output int lat);
        lat = 0;
        for (int i = 0; i < 4 * SL; i++) begin
            step();
            lat++;
            if (port == 0 ? p0_ack : p1_ack) return;
        end
        timeout_fail("wait_ack");
    endtask

    task automatic p1_drive(input logic r, input logic [20:0] a, input logic [15:0] d,
                            input logic [1:0] b);
        p1_req = 1'b1; p1_rnw = r; p1_addr = a; p1_wrdata = d; p1_bsel = b;
    endtask

    initial begin
        int lat;
        int n_cyc;
        int n_rv;
        rst_n = 1'b0; p0_req = 0; p0_addr = 0; p1_req = 0; p1_rnw = 0;
        p1_addr = 0; p1_wrdata = 0; p1_bsel = 0; sram_do = 0;

        // reset state
        repeat (3) step();
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_p1_rdata", 32'(p1_rdata), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_cyc", 32'(cyc), 1);

        // CPU read of 21'h00123, data A55A presented at slot count 7
        wait_cnt(SL - 1);
        p1_drive(1'b1, 21'h00123, 16'h0000, 2'b11);
        wait_ack(1, lat);
        chk("rd_ack_lat", 32'(lat), 1);
        chk("rd_addr", 32'(addr), 32'h00000123);
        chk("rd_rnw", 32'(rnw), 1);
        chk("rd_req", 32'(req), 1);
        p1_req = 1'b0;
        hold_do = 1'b1;
        sram_do = 16'hA55A;
        repeat (8) step();
        chk("rd_rvalid", 32'(p1_rvalid), 1);
        chk("rd_rdata", 32'(p1_rdata), 32'h0000A55A);
        hold_do = 1'b0;

        // CPU write of BEEF to 21'h1FFFFF, upper byte only
        wait_cnt(SL - 1);
        p1_drive(1'b0, 21'h1FFFFF, 16'hBEEF, 2'b10);
        wait_ack(1, lat);
        p1_req = 1'b0;
        for (int i = 0; i < SL; i++) begin
            chk("wr_rnw", 32'(rnw), 0);
            chk("wr_wrdata", 32'(wrdata), 32'h0000BEEF);
            chk("wr_bsel", 32'(bsel), 2);
            chk("wr_addr", 32'(addr), 32'h001FFFFF);
            step();
        end
        chk("wr_no_rvalid", 32'(p1_rvalid), 0);
        chk("wr_rdata_hold", 32'(p1_rdata), 32'h0000A55A);

        // both ports request continuously for 10 slots
        wait_cnt(SL - 1);
        p0_req = 1'b1; p0_addr = 21'h00400;
        p1_drive(1'b1, 21'h00777, 16'h0000, 2'b11);
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_REQ_FAIR_EN
            exp_q.push_back(1'(i % 2));
`else
            exp_q.push_back(1'b0);
`endif
        end
        log_acks = 1'b1;
        repeat (10 * SL) step();
        p0_req = 1'b0; p1_req = 1'b0;
        step();
        log_acks = 1'b0;
        chk("cont_ack_count", 32'(got_q.size()), 10);
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("cont_ack_port", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));

        // idle slots: strobes only, no requests
        wait_cnt(0);
        n_cyc = 0;
        for (int i = 0; i < 4 * SL; i++) begin
            if (cyc) n_cyc++;
            chk("idle_req", 32'(req), 0);
            chk("idle_c1", 32'(c1), 32'(i % SL == 2));
            chk("idle_c3", 32'(c3), 32'(i % SL == 6));
            step();
        end
        chk("idle_cyc_count", 32'(n_cyc), 4);

        // reset at count 3 of a video read slot, held for one slot length
        wait_cnt(SL - 1);
        p0_req = 1'b1; p0_addr = 21'h00055;
        wait_ack(0, lat);
        p0_req = 1'b0;
        wait_cnt(3);
        rst_n = 1'b0;
        n_rv = 0;
        for (int i = 0; i < SL; i++) begin
            step();
            if (p0_rvalid) n_rv++;
            chk("mr_req", 32'(req), 0);
            chk("mr_cyc", 32'(cyc), 0);
            chk("mr_addr", 32'(addr), 0);
            chk("mr_p0_rdata", 32'(p0_rdata), 0);
        end
        rst_n = 1'b1;
        #1;
        chk("mr_rel_cyc", 32'(cyc), 1);
        for (int i = 0; i < SL; i++) begin
            if (p0_rvalid) n_rv++;
            chk("mr_idle_req", 32'(req), 0);
            step();
        end
        chk("mr_no_rvalid", 32'(n_rv), 0);

        // request raised at count 0 waits a full slot
        wait_cnt(0);
        p1_drive(1'b1, 21'h00005, 16'h0000, 2'b11);
        wait_ack(1, lat);
        chk("lat_from_cnt0", 32'(lat), SL);
        p1_req = 1'b0;
        repeat (2 * SL) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
